fifo_rd_stream: RTL and testbench

Read-side drain engine for the dual-clock FIFO, living entirely in the read clock domain. It issues pop requests against the FIFO's read port, absorbs the one-cycle RAM read latency, and presents the popped words as a valid/ready stream with burst framing (`m_last` every `BURST` beats). A two-entry output buffer with pop-credit accounting sustains one word per cycle, and the FIFO is never popped while empty or when no buffer slot is free.

---
 rtl/fifo_rd_pkg.sv | 10 +
 rtl/fifo_rd_stream_skid_buf2.sv | 35 +++
 rtl/fifo_rd_stream.sv | 49 ++++
 tb/tb_fifo_rd_stream.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared widths and limits for the FIFO read-side drain engine
package fifo_rd_pkg;
  localparam int DEF_BURST = 8;
  localparam int OCC_W = 2;
  localparam logic [OCC_W-1:0] OCC_MAX = 2'd2;
  function automatic int beat_w(int burst);
    return $clog2(burst) + 1;
  endfunction
  localparam int BEAT_W = beat_w(DEF_BURST);
endpackage

// File: rtl/fifo_rd_stream_skid_buf2.sv
// skid_buf2: 2-entry in-order register buffer (push/din in, pop in, dout=head, occ out)
module skid_buf2
  import fifo_rd_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DW-1:0]    din,
  input  logic             pop,
  output logic [DW-1:0]    dout,
  output logic [OCC_W-1:0] occ
);
  logic [DW-1:0] e0, e1, e0_n, e1_n;
  always_comb begin
    e0_n = (pop && occ == OCC_MAX) ? e1 :
           (push && (occ == '0 || (pop && occ == 2'd1))) ? din : e0;
    e1_n = (push && ((occ == 2'd1 && !pop) || (occ == OCC_MAX && pop))) ? din : e1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      e0  <= '0;
      e1  <= '0;
      occ <= '0;
    end else begin
      e0  <= e0_n;
      e1  <= e1_n;
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
    end
  end
  always_ff @(posedge clk)
    if (!rst && push && !pop) assert (occ != OCC_MAX);
  assign dout = e0;
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops a FIFO read port with credit control and streams words (m_valid/m_ready/m_data/m_last/beat_cnt)
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DW    = 16,
  parameter int BURST = DEF_BURST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_rempty,
  output logic                  fifo_rden,
  input  logic [DW-1:0]         fifo_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DW-1:0]         m_data,
  output logic                  m_last,
  output logic [beat_w(BURST)-1:0] beat_cnt
);
  localparam int BW = beat_w(BURST);
  logic             inflight, pop_out;
  logic [OCC_W-1:0] occ;
  logic [2:0]       cred;
  skid_buf2 #(.DW(DW)) u_buf (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .din  (fifo_rdata),
    .pop  (pop_out),
    .dout (m_data),
    .occ  (occ)
  );
  always_comb begin
    m_valid   = occ != '0;
    pop_out   = m_valid && m_ready;
    cred      = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop_out};
    fifo_rden = en && !fifo_rempty && !rst && cred < {1'b0, OCC_MAX};
    m_last    = m_valid && beat_cnt == BW'(BURST - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      beat_cnt <= '0;
    end else begin
      inflight <= fifo_rden;
      beat_cnt <= !pop_out ? beat_cnt : (beat_cnt == BW'(BURST - 1)) ? '0 : beat_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: scoreboard bench with a FIFO read-port model for fifo_rd_stream
module tb_fifo_rd_stream;
  localparam int DW = 16;
  localparam int BURST = 8;
  logic clk = 0, rst = 1, en = 0, fifo_rempty = 1, m_ready = 0, force_e = 0;
  logic fifo_rden, m_valid, m_last;
  logic [DW-1:0] fifo_rdata = '0, m_data;
  logic [3:0] beat_cnt;
  logic [DW-1:0] mem [256];
  logic [7:0] rp = 0, wp = 0;
  logic [DW-1:0] exp_q [$];
  int checks = 0, errors = 0, acc = 0, npop = 0, ndel = 0;
  logic prev_v = 0, prev_r = 0, prev_l = 0;
  logic [DW-1:0] prev_d = '0;
  fifo_rd_stream #(.DW(DW), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_rempty(fifo_rempty), .fifo_rden(fifo_rden),
    .fifo_rdata(fifo_rdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .beat_cnt(beat_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic load(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      mem[wp] = rnd ? DW'($urandom) : DW'(i + 1);
      exp_q.push_back(mem[wp]);
      wp++;
    end
  endtask
  task automatic cyc();
    logic p;
    fifo_rempty = force_e || rp == wp;
    #1;
    p = fifo_rden;
    chk("rden_gate", 32'(fifo_rden && fifo_rempty), 0);
    if (prev_v && !prev_r) begin
      chk("hold_valid", 32'(m_valid), 1);
      chk("hold_data", 32'(m_data), 32'(prev_d));
      chk("hold_last", 32'(m_last), 32'(prev_l));
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("extra_word", 32'(m_data), 32'hdead);
      else chk("data", 32'(m_data), 32'(exp_q.pop_front()));
      chk("last", 32'(m_last), 32'(acc % BURST == BURST - 1));
      chk("beat", 32'(beat_cnt), 32'(acc % BURST));
      acc++;
      ndel++;
    end
    prev_v = m_valid; prev_r = m_ready; prev_d = m_data; prev_l = m_last;
    @(posedge clk);
    #1;
    if (p) begin
      fifo_rdata = mem[rp];
      rp++;
      npop++;
    end
  endtask
  task automatic do_rst();
    rst = 1;
    fifo_rempty = force_e || rp == wp;
    #1;
    chk("rst_rden", 32'(fifo_rden), 0);
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_beat", 32'(beat_cnt), 0);
    rp = wp;
    exp_q.delete();
    rst = 0;
    acc = 0; npop = 0; ndel = 0; prev_v = 0;
  endtask
  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask
  initial begin
    int k;
    do_rst();
    load(16, 0);
    en = 1; m_ready = 1;
    k = 0;
    while (ndel == 0 && k < 20) begin
      cyc();
      k++;
    end
    chk("first_lat", k, 3);
    for (int i = 0; i < 15; i++) cyc();
    chk("burst_nogap", ndel, 16);
    for (int i = 0; i < 3; i++) cyc();
    chk("idle_valid", 32'(m_valid), 0);
    do_rst();
    load(16, 0);
    m_ready = 0;
    for (int i = 0; i < 10; i++) cyc();
    chk("bp_pops", npop, 2);
    chk("bp_valid", 32'(m_valid), 1);
    chk("bp_data", 32'(m_data), 1);
    m_ready = 1;
    for (int i = 0; i < 16; i++) cyc();
    chk("bp_nogap", ndel, 16);
    drain(10);
    do_rst();
    force_e = 1;
    load(4, 0);
    for (int i = 0; i < 3; i++) cyc();
    force_e = 0;
    cyc();
    force_e = 1;
    for (int i = 0; i < 5; i++) cyc();
    chk("pulse_pops", npop, 1);
    chk("pulse_words", ndel, 1);
    force_e = 0;
    do_rst();
    load(200, 1);
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      m_ready = 1'($urandom_range(0, 1));
      cyc();
      k++;
    end
    chk("rand_done", exp_q.size(), 0);
    chk("rand_count", ndel, 200);
    m_ready = 1;
    for (int i = 0; i < 4; i++) cyc();
    chk("rand_nodup", ndel, 200);
    do_rst();
    load(4, 0);
    cyc();
    en = 0;
    for (int i = 0; i < 6; i++) cyc();
    chk("en_pops", npop, 1);
    chk("en_words", ndel, 1);
    en = 1;
    drain(20);
    chk("en_total", ndel, 4);
    do_rst();
    load(12, 0);
    k = 0;
    while (ndel < 5 && k < 30) begin
      cyc();
      k++;
    end
    m_ready = 0;
    for (int i = 0; i < 3; i++) cyc();
    chk("pre_rst_beat", 32'(beat_cnt), 5);
    chk("pre_rst_valid", 32'(m_valid), 1);
    do_rst();
    load(3, 0);
    m_ready = 1;
    drain(20);
    chk("post_rst_words", ndel, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
